// File: rtl/instr_mem_responder.sv
// Memory-side responder for the fetch/memory stall handshake with a one-entry last-read buffer.
// Optional feature: define UNALIGNED_ERR_EN to reject requests with Addr[0]=1.
module instr_mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned MEM_AW  = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);
    localparam int unsigned DEPTH = 2 ** MEM_AW;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                buf_valid_q, buf_valid_d;
    logic [MEM_AW-1:0]   buf_tag_q, buf_tag_d;
    logic [15:0]         buf_data_q, buf_data_d;
    logic [15:0]         dout_q, dout_d;
    logic                done_q, done_d;
    logic                stall_q, stall_d;
    logic                hit_q, hit_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic [15:0]         mem [DEPTH];

    logic [MEM_AW-1:0]   req_idx;
    logic                req_bad;
    logic                unused_addr;

    assign req_idx     = Addr[MEM_AW:1];
    assign unused_addr = ^Addr;

`ifdef UNALIGNED_ERR_EN
    assign req_bad = (Rd & Wr) | ((Rd ^ Wr) & Addr[0]);
`else
    assign req_bad = Rd & Wr;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        dout_d      = '0;
        done_d      = 1'b0;
        stall_d     = 1'b0;
        hit_d       = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_bad) begin
                    err_d = 1'b1;
                end else if (Rd ^ Wr) begin
                    if (Rd && buf_valid_q && (req_idx == buf_tag_q)) begin
                        done_d = 1'b1;
                        hit_d  = 1'b1;
                        dout_d = buf_data_q;
                    end else begin
                        op_wr_d = Wr;
                        idx_d   = req_idx;
                        wdata_d = DataIn;
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = BUSY;
                        stall_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 4'd1;
                    stall_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                        // Keep the read buffer coherent with the array.
                        if (idx_q == buf_tag_q) buf_data_d = wdata_q;
                    end else begin
                        dout_d      = mem[idx_q];
                        buf_tag_d   = idx_q;
                        buf_data_d  = mem[idx_q];
                        buf_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            stall_q     <= 1'b0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            stall_q     <= stall_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[idx_q] <= wdata_q;
    end

    assign DataOut  = dout_q;
    assign Done     = done_q;
    assign Stall    = stall_q;
    assign CacheHit = hit_q;
    assign err      = err_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed vector table, reset/idle sequences, randomized traffic vs a model.
module tb_instr_mem_responder;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, Rd, Wr;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Done, Stall, CacheHit, err;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_mem_responder #(.LATENCY(LAT), .MEM_AW(9)) dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: word array plus the last-read buffer.
    logic [15:0] m_mem [512];
    bit          m_bv;
    int          m_tag;
    logic [15:0] m_bdata;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          stall;
        logic [15:0] dout;
        bit          hit;
        bit          er;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                         output int es, output logic [15:0] ed, output bit eh, output bit ee);
        int idx;
        idx = int'(a[9:1]);
        es = 0; ed = 16'h0; eh = 0; ee = 0;
        if ((rd && wr) || (!rd && !wr)) begin
            ee = rd && wr;
        end
`ifdef UNALIGNED_ERR_EN
        else if (a[0]) ee = 1;
`endif
        else if (rd) begin
            if (m_bv && m_tag == idx) begin
                eh = 1; ed = m_bdata;
            end else begin
                es = LAT; ed = m_mem[idx];
                m_bv = 1; m_tag = idx; m_bdata = m_mem[idx];
            end
        end else begin
            es = LAT;
            m_mem[idx] = d;
            if (m_tag == idx) m_bdata = d;
        end
    endtask

    // Drives at the current negedge; returns at the negedge where the response is visible.
    task automatic run_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                           input int es, input logic [15:0] ed, input bit eh, input bit ee,
                           input string name);
        int n;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        @(negedge clk);
        n = 0;
        while (Stall && n < 40) begin
            Rd = 1'($urandom); Wr = 1'($urandom); Addr = 16'($urandom); DataIn = 16'($urandom);
            n++;
            @(negedge clk);
        end
        Rd = 0; Wr = 0;
        chk({name, " stall_cycles"}, 32'(n), 32'(es));
        chk({name, " Done"}, 32'(Done), 32'(!ee));
        chk({name, " DataOut"}, 32'(DataOut), 32'(ed));
        chk({name, " CacheHit"}, 32'(CacheHit), 32'(eh));
        chk({name, " err"}, 32'(err), 32'(ee));
    endtask

    task automatic go(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input string name);
        int es; logic [15:0] ed; bit eh, ee;
        model(rd, wr, a, d, es, ed, eh, ee);
        run_req(rd, wr, a, d, es, ed, eh, ee, name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " Done"}, 32'(Done), 0);
        chk({name, " Stall"}, 32'(Stall), 0);
        chk({name, " CacheHit"}, 32'(CacheHit), 0);
        chk({name, " err"}, 32'(err), 0);
        chk({name, " DataOut"}, 32'(DataOut), 0);
    endtask

    vec_t vecs [10];

    initial begin
        int es; logic [15:0] ed; bit eh, ee;
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, LAT, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, LAT, 16'hBEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0,   16'hBEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0010, 16'h1234, LAT, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0,   16'h1234, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h7777, 0,   16'h0000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0,   16'h1234, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h0410, 16'h0000, 0,   16'h1234, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h0412, 16'hA5A5, LAT, 16'h0000, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'h0012, 16'h0000, LAT, 16'hA5A5, 1'b0, 1'b0};

        m_bv = 0; m_tag = 0; m_bdata = 16'h0;
        rst = 1; Rd = 0; Wr = 0; Addr = 16'h0; DataIn = 16'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;

        foreach (vecs[i]) begin
            model(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, es, ed, eh, ee);
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].stall, vecs[i].dout, vecs[i].hit, vecs[i].er, $sformatf("vec%0d", i));
        end

        @(negedge clk);
        chk_all_zero("idle");

        // Reset in the middle of a miss aborts it and invalidates the buffer.
        Rd = 1; Addr = 16'h0020;
        @(negedge clk);
        Rd = 0;
        chk("abort stall1", 32'(Stall), 1);
        @(negedge clk);
        chk("abort stall2", 32'(Stall), 1);
        rst = 1;
        @(negedge clk);
        chk_all_zero("abort_rst");
        rst = 0;
        m_bv = 0;
        run_req(1, 0, 16'h0010, 16'h0, LAT, 16'h1234, 0, 0, "post_rst_miss");
        m_bv = 1; m_tag = 8; m_bdata = 16'h1234;
        go(0, 1, 16'h0020, 16'h5555, "wr20");
        go(1, 0, 16'h0020, 16'h0, "rd20");
`ifdef UNALIGNED_ERR_EN
        run_req(1, 0, 16'h0011, 16'h0, 0, 16'h0000, 0, 1, "odd_rd");
`else
        run_req(1, 0, 16'h0011, 16'h0, LAT, 16'h1234, 0, 0, "odd_rd");
        m_tag = 8;
`endif

        for (int i = 0; i < 8; i++)
            go(0, 1, 16'(i * 2), 16'($urandom), "prewrite");

        for (int i = 0; i < 150; i++) begin
            int op;
            logic [15:0] a;
            op = int'($urandom % 8);
            a = (16'($urandom) & 16'hFC00) | 16'(($urandom % 8) * 2) | 16'(($urandom % 8) == 0);
            if (op == 0)      go(1, 1, a, 16'($urandom), "rnd_rdwr");
            else if (op <= 2) go(0, 1, a, 16'($urandom), "rnd_wr");
            else              go(1, 0, a, 16'h0, "rnd_rd");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
